// File: rtl/rho_func.sv
// Rho lane-rotation stage: buffers one 64-slice Keccak state, then replays it
// with every lane (x,y) rotated along z by its fixed rho offset.
module rho_func (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_line,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_line,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_LOAD | accepting 64 input slices into the buffer
  // S_EMIT | presenting 64 rotated output slices
  // S_DONE | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t      state_q;
  logic [5:0]  in_cnt_q, out_cnt_q;
  logic [5:0]  in_cnt_d, out_cnt_d;
  logic        in_ready_q, out_valid_q, busy_q, done_q;
  logic [24:0] buf_q [64];
  logic        in_fire, out_fire;

  // Rho offset for bit index 5*x+y.
  function automatic logic [5:0] rho_off(input int lane);
    case (lane)
      0:  return 6'd0;
      1:  return 6'd36;
      2:  return 6'd3;
      3:  return 6'd41;
      4:  return 6'd18;
      5:  return 6'd1;
      6:  return 6'd44;
      7:  return 6'd10;
      8:  return 6'd45;
      9:  return 6'd2;
      10: return 6'd62;
      11: return 6'd6;
      12: return 6'd43;
      13: return 6'd15;
      14: return 6'd61;
      15: return 6'd28;
      16: return 6'd55;
      17: return 6'd25;
      18: return 6'd21;
      19: return 6'd56;
      20: return 6'd27;
      21: return 6'd20;
      22: return 6'd39;
      23: return 6'd8;
      24: return 6'd14;
      default: return 6'd0;
    endcase
  endfunction

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign in_cnt_d  = in_cnt_q + 6'd1;
  assign out_cnt_d = out_cnt_q + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= 6'd0;
      out_cnt_q   <= 6'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            in_cnt_q   <= 6'd0;
            out_cnt_q  <= 6'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            in_cnt_q <= in_cnt_d;
            if (in_cnt_q == 6'd63) begin
              state_q     <= S_EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_fire) begin
            out_cnt_q <= out_cnt_d;
            if (out_cnt_q == 6'd63) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer contents survive reset; only the counters restart.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[in_cnt_q] <= in_line;
  end

  always_comb begin
    out_line = '0;
    for (int i = 0; i < 25; i++) begin
      out_line[i] = buf_q[out_cnt_q - rho_off(i)][i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rho_func.sv
// Scoreboard bench for rho_func: expected slices are queued from a reference
// rotation model when a state is driven, and popped as output beats arrive.
module tb_rho_func;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_line;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_line;
  logic        busy;
  logic        done;

  rho_func dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Offsets as rows per y, entries for x = 0..4.
  int ry [5][5] = '{'{0, 1, 62, 28, 27},
                    '{36, 44, 6, 55, 20},
                    '{3, 10, 43, 25, 39},
                    '{41, 45, 15, 21, 8},
                    '{18, 2, 61, 56, 14}};

  logic [24:0] stim [64];
  logic [24:0] exp_q [$];
  logic [24:0] got_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt;
  int stall_errs;
  bit timeout;

  task automatic build_expected();
    logic [24:0] e, src;
    exp_q.delete();
    for (int z = 0; z < 64; z++) begin
      e = '0;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++) begin
          src = stim[(z - ry[y][x]) & 63];
          e[5*x+y] = src[5*x+y];
        end
      exp_q.push_back(e);
    end
  endtask

  // Drives one full state from stim[] and collects output beats into got_q.
  task automatic run_state(input int gap_pct, input int stall_pct, input bit poke_start);
    int in_idx, cyc, post;
    bit pv, pr;
    logic [24:0] pl;
    got_q.delete();
    done_cnt = 0; stall_errs = 0; timeout = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_idx = 0; cyc = 0; post = 0; pv = 1'b0; pr = 1'b0; pl = '0;
    while (1) begin
      in_valid  = (in_idx < 64) && (int'($urandom_range(99)) >= gap_pct);
      in_line   = in_valid ? stim[in_idx] : 25'($urandom());
      out_ready = int'($urandom_range(99)) >= stall_pct;
      start     = poke_start && ((in_idx == 10 && in_ready) || (got_q.size() == 10 && out_valid));
      if (pv && !pr && out_valid && out_line !== pl) stall_errs++;
      if (done) done_cnt++;
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) got_q.push_back(out_line);
      pv = out_valid; pr = out_ready; pl = out_line;
      if (done_cnt > 0) post++;
      if (post > 3) break;
      cyc++;
      if (cyc > 2000) begin timeout = 1'b1; break; end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    int idx, dn;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_line = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({in_ready, out_valid, busy, done} !== 4'b0) $display("FAIL rst_init got=%b want=0000", {in_ready, out_valid, busy, done}); else n_pass++;
    rst = 1'b0;
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; dn = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid = idx < 64;
      in_line = (idx < 64) ? stim[idx] : '0;
      out_ready = 1'b1;
      if (done) dn++;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rst_in_emit got=%b want=1", out_valid); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    n_checks++; if ({in_ready, out_valid, busy, done} !== 4'b0) $display("FAIL rst_mid_emit got=%b want=0000", {in_ready, out_valid, busy, done}); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    n_checks++; if (dn !== 0) $display("FAIL rst_no_done got=%0d want=0", dn); else n_pass++;
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    build_expected();
    run_state(0, 0, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL rst_rerun_count got=%0d want=64", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL rst_rerun_slice got=%h want=%h", g, e); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL rst_rerun_done got=%0d want=1", done_cnt); else n_pass++;
  endtask

  task automatic test_single_bit();
    for (int z = 0; z < 64; z++) stim[z] = '0;
    stim[0] = 25'h20;
    build_expected();
    run_state(0, 0, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL single_count got=%0d want=64", got_q.size()); else n_pass++;
    for (int z = 0; z < 64 && got_q.size() > 0; z++) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== ((z == 1) ? 25'h20 : 25'h0)) $display("FAIL single_slice%0d got=%h want=%h", z, g, (z == 1) ? 25'h20 : 25'h0); else n_pass++;
      n_checks++; if (g !== e) $display("FAIL single_model%0d got=%h want=%h", z, g, e); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL single_done got=%0d want=1", done_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int z = 0; z < 64; z++) stim[z] = '0;
    stim[3] = 25'h400;
    build_expected();
    run_state(0, 0, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL wrap_count got=%0d want=64", got_q.size()); else n_pass++;
    for (int z = 0; z < 64 && got_q.size() > 0; z++) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== ((z == 1) ? 25'h400 : 25'h0)) $display("FAIL wrap_slice%0d got=%h want=%h", z, g, (z == 1) ? 25'h400 : 25'h0); else n_pass++;
      n_checks++; if (g !== e) $display("FAIL wrap_model%0d got=%h want=%h", z, g, e); else n_pass++;
    end
  endtask

  task automatic test_identity();
    logic [5:0] zz;
    for (int z = 0; z < 64; z++) begin
      zz = 6'(z);
      stim[z] = {24'($urandom()), zz[0]};
    end
    build_expected();
    run_state(20, 20, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL ident_count got=%0d want=64", got_q.size()); else n_pass++;
    for (int z = 0; z < 64 && got_q.size() > 0; z++) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      zz = 6'(z);
      n_checks++; if (g[0] !== zz[0]) $display("FAIL ident_bit0_%0d got=%b want=%b", z, g[0], zz[0]); else n_pass++;
      n_checks++; if (g !== e) $display("FAIL ident_model%0d got=%h want=%h", z, g, e); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    build_expected();
    run_state(30, 50, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL bp_count got=%0d want=64", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL bp_slice got=%h want=%h", g, e); else n_pass++;
    end
    n_checks++; if (stall_errs != 0) $display("FAIL bp_stable got=%0d want=0", stall_errs); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL bp_done got=%0d want=1", done_cnt); else n_pass++;
  endtask

  task automatic test_protocol();
    int idx, cyc;
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    build_expected();
    run_state(10, 30, 1'b1);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL proto_start_count got=%0d want=64", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL proto_start_slice got=%h want=%h", g, e); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL proto_start_done got=%0d want=1", done_cnt); else n_pass++;
    // Partial load of 30 slices, then reset and a fresh state.
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 30 && cyc < 200) begin
      in_valid = 1'b1; in_line = stim[idx];
      if (in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (idx != 30) $display("FAIL proto_partial got=%0d want=30", idx); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({in_ready, busy} !== 2'b00) $display("FAIL proto_rst got=%b want=00", {in_ready, busy}); else n_pass++;
    for (int z = 0; z < 64; z++) stim[z] = 25'($urandom());
    build_expected();
    run_state(0, 0, 1'b0);
    n_checks++; if (timeout || got_q.size() != 64) $display("FAIL proto_fresh_count got=%0d want=64", got_q.size()); else n_pass++;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [24:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g !== e) $display("FAIL proto_fresh_slice got=%h want=%h", g, e); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_line = '0;
    test_reset();
    test_single_bit();
    test_wrap();
    test_identity();
    test_backpressure();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rho_func.md
# rho_func

Rho (lane-rotation) stage of the matrix encoder. It sits directly upstream of the permutation stage. It accepts one full 5x5x64 state as 64 slice lines of 25 bits, buffers the whole state, then emits 64 slice lines in which every lane (x,y) is rotated along z by the fixed Keccak rho offset. The emitted lines feed the permutation stage in slice order 0..63.

## Interface
Parameters:
- none. Geometry is fixed at 25-bit slice lines, 64 slices per state.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to process one state; honoured only in IDLE.
- in_valid  input  1  in_line carries a valid slice.
- in_ready  output  1  block accepts a slice this cycle.
- in_line  input  25  input slice z, with z implied by arrival order 0..63. Bit index of lane (x,y) is 5*x+y.
- out_valid  output  1  out_line carries a valid slice.
- out_ready  input  1  downstream accepts out_line this cycle.
- out_line  output  25  output slice z, in order 0..63, same bit mapping as in_line.
- busy  output  1  high in LOAD and EMIT.
- done  output  1  one-cycle pulse after the last output slice is accepted.

## Operation
- Storage: 64x25 flop array buf, written at address in_cnt. Contents are not cleared by reset.
- Counters: in_cnt and out_cnt, 6 bits each, both zero on reset and on entering LOAD.
- Rotation: out_line bit(x,y) = buf[(out_cnt - r[x][y]) mod 64] bit(x,y). Subtraction is 6-bit wrap-around. Read is combinational from buf and out_cnt.
- Offsets r[x][y], listed for x=0..4 at each y:
  - y0: 0,1,62,28,27
  - y1: 36,44,6,55,20
  - y2: 3,10,43,25,39
  - y3: 41,45,15,21,8
  - y4: 18,2,61,56,14
- FSM states and transitions:
  - IDLE: start goes to LOAD, otherwise stay.
  - LOAD: in_ready=1. On each in_valid&in_ready, buf[in_cnt]<=in_line and in_cnt increments. The beat accepted with in_cnt==63 goes to EMIT.
  - EMIT: out_valid=1. On each out_valid&out_ready, out_cnt increments. The beat accepted with out_cnt==63 goes to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored; in_ready=0 there.
- A beat is transferred only when valid and ready are both high. Held out_valid with out_ready=0 keeps out_line and out_cnt stable.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, busy=0, done=0, in_cnt=0, out_cnt=0. out_line is don't-care while out_valid=0.
- Reset asserted in any state forces all of the above on the next edge. Any partial load or emit is abandoned, and no done pulse is produced.
- start sampled high in IDLE makes in_ready=1 from the next cycle.
- EMIT begins the cycle after the 64th input beat, so out_valid is high one cycle after the last accepted input.
- done is high the cycle after the 64th output beat.
- Minimum state latency with no stalls is 1 (start) + 64 (load) + 64 (emit) + 1 (done) = 130 cycles from start to done.
- in_cnt and out_cnt wrap 63->0 at the same edge as the state change. There is no separate terminal-count register.
- start and done never coincide in the same cycle, because start is ignored in DONE.

## Test plan
- Reset: assert rst for 2 cycles mid-EMIT. Next cycle must show state IDLE, out_valid=0, in_ready=0, busy=0, done=0. A following full run must complete normally.
- Single bit, lane (1,0): only in_line[5] set in slice 0, all other slices 0. Output must be slice 1 = 25'h20, all other slices 0.
- Wrap-around, lane (2,0): only in_line[10] set in slice 3. Output must be bit 10 set in slice 1 only, since (3+62) mod 64 = 1.
- Identity lane: in_line[0] toggled per slice, pattern slice z bit0 = z[0]. out_line bit 0 must equal z[0] for every output slice.
- Backpressure: out_ready random at 50%, with in_valid gaps during load. The 64 outputs must match a reference model, out_line must be stable while stalled, and done must fire exactly once.
- Protocol: start pulsed during LOAD and again during EMIT must be ignored. Reset at in_cnt=30 followed by a fresh start must load a new state from slice 0.
